// File: rtl/issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// issue_ctrl_pkg / issue_ctrl_if
//
// Purpose: shared ALU opcode type plus the decoder <-> scheduler bundle used
// by issue_ctrl.
//
// Port summary (interface members):
//   i_valid, i_select_a/b/c, i_is_write, i_is_load, i_is_store, i_is_cmp,
//   i_alu_op, i_flush   : decoded instruction presented by the decoder
//   o_ready, o_issue    : combinational issue decision
//   o_stall_raw/waw/div : reason the presented instruction is held
//   o_pending           : per-register "result outstanding" vector
//   o_div_busy          : multi-cycle divider occupied
//
// Modports: master = decoder side, slave = scheduler side.
// ---------------------------------------------------------------------------
package issue_ctrl_pkg;
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_MUL = 3'd5,
        ALU_DIV = 3'd6,
        ALU_NOP = 3'd7
    } alu_op_e;
endpackage

interface issue_ctrl_if #(
    parameter int NUM_REG = 32
);
    localparam int REG_SELECT = $clog2(NUM_REG);

    logic                        i_valid;
    logic [REG_SELECT-1:0]       i_select_a;
    logic [REG_SELECT-1:0]       i_select_b;
    logic [REG_SELECT-1:0]       i_select_c;
    logic                        i_is_write;
    logic                        i_is_load;
    logic                        i_is_store;
    logic                        i_is_cmp;
    issue_ctrl_pkg::alu_op_e     i_alu_op;
    logic                        i_flush;

    logic                        o_ready;
    logic                        o_issue;
    logic                        o_stall_raw;
    logic                        o_stall_waw;
    logic                        o_stall_div;
    logic [NUM_REG-1:0]          o_pending;
    logic                        o_div_busy;

    modport master (
        output i_valid, i_select_a, i_select_b, i_select_c,
               i_is_write, i_is_load, i_is_store, i_is_cmp,
               i_alu_op, i_flush,
        input  o_ready, o_issue, o_stall_raw, o_stall_waw, o_stall_div,
               o_pending, o_div_busy
    );

    modport slave (
        input  i_valid, i_select_a, i_select_b, i_select_c,
               i_is_write, i_is_load, i_is_store, i_is_cmp,
               i_alu_op, i_flush,
        output o_ready, o_issue, o_stall_raw, o_stall_waw, o_stall_div,
               o_pending, o_div_busy
    );
endinterface

// File: rtl/issue_ctrl.sv
// ---------------------------------------------------------------------------
// issue_ctrl
//
// Purpose: in-order issue scheduler. Holds the decoded instruction until its
// sources/destination carry no outstanding result and, for DIV, the divider
// is idle. A per-register countdown (scoreboard) is loaded with the latency
// of the producing operation on issue and counts down to zero.
//
// Ports:
//   i_clk  : clock, rising edge
//   i_rst  : synchronous active-high reset (clears scoreboard and divider)
//   bus    : issue_ctrl_if.slave (instruction in, issue/stall/status out)
//
// Optional feature: define ISSUE_CTRL_FWD_EN to let ALU-class results with
// one cycle left (cnt == 1) be treated as available for hazard checks.
// ---------------------------------------------------------------------------
module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int NUM_REG  = 32,
    parameter int LAT_ALU  = 1,
    parameter int LAT_MUL  = 3,
    parameter int LAT_DIV  = 8,
    parameter int LAT_LOAD = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    issue_ctrl_if.slave bus
);
    localparam int REG_SELECT = $clog2(NUM_REG);
    localparam int LAT_M0     = (LAT_ALU > LAT_MUL) ? LAT_ALU : LAT_MUL;
    localparam int LAT_M1     = (LAT_M0 > LAT_DIV) ? LAT_M0 : LAT_DIV;
    localparam int LAT_MAX    = (LAT_M1 > LAT_LOAD) ? LAT_M1 : LAT_LOAD;
    localparam int CW         = $clog2(LAT_MAX + 1);

    logic [NUM_REG-1:0]    pending_vec;
    logic [NUM_REG-1:0]    blocked_vec;   // pending as seen by hazard checks
    logic [REG_SELECT-1:0] dest_sel;
    logic [CW-1:0]         lat_sel;
    logic                  is_div;
    logic                  raw_c;
    logic                  waw_c;
    logic                  div_c;
    logic                  ready_c;
    logic                  issue_c;
    logic                  div_busy;
    logic [CW-1:0]         div_cnt_reg;
    logic [CW-1:0]         div_cnt_next;
    logic                  unused_flags;

    // Store and compare flags only matter to the decoder; a non-writing
    // instruction is handled purely through i_is_write being low.
    assign unused_flags = ^{bus.i_is_store, bus.i_is_cmp};

    // ---------------- hazard evaluation ----------------
    assign dest_sel = bus.i_is_load ? bus.i_select_b : bus.i_select_c;
    assign is_div   = (bus.i_alu_op == ALU_DIV) && bus.i_is_write;

    always_comb begin
        lat_sel = CW'(LAT_ALU);
        if (bus.i_is_load) begin
            lat_sel = CW'(LAT_LOAD);
        end else if (bus.i_alu_op == ALU_MUL) begin
            lat_sel = CW'(LAT_MUL);
        end else if (bus.i_alu_op == ALU_DIV) begin
            lat_sel = CW'(LAT_DIV);
        end
    end

    // Source B is the load destination for LW, so it is not a read then.
    assign raw_c   = blocked_vec[bus.i_select_a] ||
                     (!bus.i_is_load && blocked_vec[bus.i_select_b]);
    assign waw_c   = bus.i_is_write && blocked_vec[dest_sel];
    assign div_c   = is_div && div_busy;
    assign ready_c = !i_rst && !raw_c && !waw_c && !div_c;
    assign issue_c = bus.i_valid && ready_c && !bus.i_flush;

`ifdef ISSUE_CTRL_FWD_EN
    logic alu_class;
    assign alu_class = !bus.i_is_load &&
                       (bus.i_alu_op != ALU_MUL) && (bus.i_alu_op != ALU_DIV);
`endif

    // ---------------- per-register scoreboard ----------------
    generate
        for (genvar gi = 0; gi < NUM_REG; gi++) begin : g_reg
            logic [CW-1:0] cnt_reg;
            logic [CW-1:0] cnt_next;
            logic          load_hit;

            assign load_hit = issue_c && bus.i_is_write &&
                              (dest_sel == REG_SELECT'(gi));

            // A new producer overrides the running countdown.
            always_comb begin
                cnt_next = cnt_reg;
                if (load_hit) begin
                    cnt_next = lat_sel;
                end else if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end

            assign pending_vec[gi] = (cnt_reg != '0);

`ifdef ISSUE_CTRL_FWD_EN
            logic fwd_reg;

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    fwd_reg <= 1'b0;
                end else if (load_hit) begin
                    fwd_reg <= alu_class;
                end
            end

            // Last cycle of an ALU result can be bypassed to the consumer.
            assign blocked_vec[gi] = pending_vec[gi] &&
                                     !((cnt_reg == CW'(1)) && fwd_reg);
`else
            assign blocked_vec[gi] = pending_vec[gi];
`endif
        end
    endgenerate

    // ---------------- divider occupancy ----------------
    always_comb begin
        div_cnt_next = div_cnt_reg;
        if (issue_c && is_div) begin
            div_cnt_next = CW'(LAT_DIV);
        end else if (div_cnt_reg != '0) begin
            div_cnt_next = div_cnt_reg - CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_next;
        end
    end

    assign div_busy = (div_cnt_reg != '0);

    // ---------------- outputs ----------------
    assign bus.o_ready     = ready_c;
    assign bus.o_issue     = issue_c;
    assign bus.o_stall_raw = bus.i_valid && !i_rst && raw_c;
    assign bus.o_stall_waw = bus.i_valid && !i_rst && waw_c;
    assign bus.o_stall_div = bus.i_valid && !i_rst && div_c;
    assign bus.o_pending   = pending_vec;
    assign bus.o_div_busy  = div_busy;

endmodule

// File: tb/tb_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_issue_ctrl
//
// Purpose: self-checking bench for issue_ctrl. The reference model tracks,
// per register, the absolute cycle at which its result stops being pending
// (and, with ISSUE_CTRL_FWD_EN, the cycle it becomes usable), plus the cycle
// the divider frees up. A compare process checks every DUT output against
// that model each cycle; directed scenarios pin the model with literal
// issue distances and stall counts; a random phase follows.
// ---------------------------------------------------------------------------
module tb_issue_ctrl;
    import issue_ctrl_pkg::*;

    localparam int NR       = 32;
    localparam int LAT_ALU  = 1;
    localparam int LAT_MUL  = 3;
    localparam int LAT_DIV  = 8;
    localparam int LAT_LOAD = 2;
`ifdef ISSUE_CTRL_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    issue_ctrl_if #(.NUM_REG(NR)) bus();

    issue_ctrl #(
        .NUM_REG (NR),
        .LAT_ALU (LAT_ALU),
        .LAT_MUL (LAT_MUL),
        .LAT_DIV (LAT_DIV),
        .LAT_LOAD(LAT_LOAD)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    // Model state: absolute cycle numbers.
    int free_at  [NR];
    int avail_at [NR];
    int div_free = 0;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    // ---------------- per-cycle compare against the model ----------------
    initial begin
        logic          m_raw, m_waw, m_divs, m_rdy, m_iss, m_busy;
        logic [NR-1:0] m_pend;
        int            a, b, d, lat;
        for (int r = 0; r < NR; r++) begin
            free_at[r]  = 0;
            avail_at[r] = 0;
        end
        forever begin
            @(negedge clk);
            #2;
            a = int'(bus.i_select_a);
            b = int'(bus.i_select_b);
            d = bus.i_is_load ? b : int'(bus.i_select_c);
            for (int r = 0; r < NR; r++) m_pend[r] = (cyc < free_at[r]);
            m_raw  = (cyc < avail_at[a]) || (!bus.i_is_load && (cyc < avail_at[b]));
            m_waw  = bus.i_is_write && (cyc < avail_at[d]);
            m_busy = (cyc < div_free);
            m_divs = (bus.i_alu_op == ALU_DIV) && bus.i_is_write && m_busy;
            m_rdy  = !rst && !m_raw && !m_waw && !m_divs;
            m_iss  = bus.i_valid && m_rdy && !bus.i_flush;
            if (check_en) begin
                chk("ready",     bus.o_ready,     m_rdy);
                chk("issue",     bus.o_issue,     m_iss);
                chk("stall_raw", bus.o_stall_raw, bus.i_valid && !rst && m_raw);
                chk("stall_waw", bus.o_stall_waw, bus.i_valid && !rst && m_waw);
                chk("stall_div", bus.o_stall_div, bus.i_valid && !rst && m_divs);
                chk("pending",   bus.o_pending,   m_pend);
                chk("div_busy",  bus.o_div_busy,  m_busy);
            end
            if (rst) begin
                for (int r = 0; r < NR; r++) begin
                    free_at[r]  = 0;
                    avail_at[r] = 0;
                end
                div_free = 0;
            end else if (m_iss && bus.i_is_write) begin
                if (bus.i_is_load)                 lat = LAT_LOAD;
                else if (bus.i_alu_op == ALU_MUL)  lat = LAT_MUL;
                else if (bus.i_alu_op == ALU_DIV)  lat = LAT_DIV;
                else                               lat = LAT_ALU;
                free_at[d]  = cyc + lat + 1;
                avail_at[d] = free_at[d] -
                              ((FWD && lat == LAT_ALU && !bus.i_is_load &&
                                bus.i_alu_op != ALU_MUL && bus.i_alu_op != ALU_DIV) ? 1 : 0);
                if (bus.i_alu_op == ALU_DIV) div_free = cyc + LAT_DIV + 1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int a, input int b, input int c, input bit wr,
                         input bit ld, input alu_op_e op);
        bus.i_valid    = 1'b1;
        bus.i_select_a = 5'(a);
        bus.i_select_b = 5'(b);
        bus.i_select_c = 5'(c);
        bus.i_is_write = wr;
        bus.i_is_load  = ld;
        bus.i_is_store = 1'b0;
        bus.i_is_cmp   = 1'b0;
        bus.i_alu_op   = op;
        bus.i_flush    = 1'b0;
    endtask

    // Presents an instruction (called right after a negedge) and holds it
    // until it issues; returns at the negedge after the issue cycle.
    task automatic present(input string nm, input int a, input int b, input int c,
                           input bit wr, input bit ld, input alu_op_e op,
                           output int delay, output int at,
                           output int nraw, output int nwaw, output int ndiv);
        int  start;
        bit  done;
        done  = 1'b0;
        delay = -1;
        at    = -1;
        nraw  = 0;
        nwaw  = 0;
        ndiv  = 0;
        drive(a, b, c, wr, ld, op);
        start = cyc;
        for (int k = 0; k < 40 && !done; k++) begin
            #1;
            nraw += int'(bus.o_stall_raw);
            nwaw += int'(bus.o_stall_waw);
            ndiv += int'(bus.o_stall_div);
            if (bus.o_issue) begin
                delay = cyc - start;
                at    = cyc;
                done  = 1'b1;
            end
            @(negedge clk);
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s issue_timeout got=none exp=issue_within_40", nm);
        end
        $display("txn %s issue_cycle=%0d delay=%0d raw=%0d waw=%0d div=%0d",
                 nm, at, delay, nraw, nwaw, ndiv);
    endtask

    task automatic idle(input int n);
        bus.i_valid    = 1'b0;
        bus.i_flush    = 1'b0;
        bus.i_is_write = 1'b0;
        bus.i_is_load  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int d0, at1, at2, at3, nr, nw, nd, dx, ax;
        drive(5, 5, 2, 1'b1, 1'b0, ALU_ADD);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        check_en = 1'b1;

        // Reset state with a valid, hazard-free instruction presented.
        @(negedge clk);
        #1;
        chk("rst_ready",   bus.o_ready,    1'b0);
        chk("rst_issue",   bus.o_issue,    1'b0);
        chk("rst_pending", bus.o_pending,  32'h0);
        chk("rst_divbusy", bus.o_div_busy, 1'b0);
        chk("rst_raw",     bus.o_stall_raw, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // ADD r2 <- r5,r5 issues at once; r2 pending for exactly one cycle.
        present("add_r2", 5, 5, 2, 1'b1, 1'b0, ALU_ADD, d0, at1, nr, nw, nd);
        chk("add_imm_delay", d0, 0);
        bus.i_valid = 1'b0;
        #1;
        chk("add_pend_t1", bus.o_pending, 32'h0000_0004);
        @(negedge clk);
        #1;
        chk("add_pend_t2", bus.o_pending, 32'h0);
        idle(4);

        // LW r7 then ADD reading r7: two RAW cycles, issue at t+3.
        present("lw_r7",   1, 7, 0,  1'b1, 1'b1, ALU_ADD, d0, at1, nr, nw, nd);
        present("add_r7",  7, 1, 11, 1'b1, 1'b0, ALU_ADD, d0, at2, nr, nw, nd);
        chk("lw_use_dist", at2 - at1, 3);
        chk("lw_use_raw",  nr, 2);
        idle(4);

        // ADD r3 then SUB reading r3.
        present("add_r3",  1, 1, 3,  1'b1, 1'b0, ALU_ADD, d0, at1, nr, nw, nd);
        present("sub_r3",  3, 1, 12, 1'b1, 1'b0, ALU_SUB, d0, at2, nr, nw, nd);
        chk("alu_use_dist", at2 - at1, FWD ? 1 : 2);
        idle(4);

        // Two independent DIVs: 8 divider stalls, second issues at t+9.
        present("div_r4",  1, 1, 4, 1'b1, 1'b0, ALU_DIV, d0, at1, nr, nw, nd);
        present("div_r6",  1, 1, 6, 1'b1, 1'b0, ALU_DIV, d0, at2, nr, nw, nd);
        chk("div_div_dist",  at2 - at1, 9);
        chk("div_div_stall", nd, 8);
        idle(10);

        // DIV, OR (independent, no stall), DIV.
        present("div_r4b", 1, 1, 4, 1'b1, 1'b0, ALU_DIV, d0, at1, nr, nw, nd);
        present("or_r9",   1, 1, 9, 1'b1, 1'b0, ALU_OR,  d0, at2, nr, nw, nd);
        chk("or_dist",   at2 - at1, 1);
        chk("or_stalls", nr + nw + nd, 0);
        present("div_r6b", 1, 1, 6, 1'b1, 1'b0, ALU_DIV, d0, at3, nr, nw, nd);
        chk("div_or_div_dist", at3 - at1, 9);
        idle(10);

        // MUL r8 then ADD writing r8: three WAW cycles.
        present("mul_r8",  1, 1, 8, 1'b1, 1'b0, ALU_MUL, d0, at1, nr, nw, nd);
        present("add_w8",  1, 1, 8, 1'b1, 1'b0, ALU_ADD, d0, at2, nr, nw, nd);
        chk("waw_stall", nw, 3);
        chk("waw_dist",  at2 - at1, 4);

        // Flush on a hazard-free cycle: ready but no issue, r10 untouched.
        drive(13, 13, 10, 1'b1, 1'b0, ALU_ADD);
        bus.i_flush = 1'b1;
        #1;
        chk("flush_ready", bus.o_ready, 1'b1);
        chk("flush_issue", bus.o_issue, 1'b0);
        @(negedge clk);
        idle(0);
        #1;
        chk("flush_sb", bus.o_pending[10], 1'b0);
        idle(10);

        // Reset while r8 pending and divider busy.
        present("mul_r8b", 1, 1, 8, 1'b1, 1'b0, ALU_MUL, d0, at1, nr, nw, nd);
        present("div_r4c", 1, 1, 4, 1'b1, 1'b0, ALU_DIV, d0, at2, nr, nw, nd);
        idle(0);
        rst = 1'b1;
        #1;
        chk("prerst_pend8", bus.o_pending[8], 1'b1);
        chk("prerst_busy",  bus.o_div_busy,   1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("postrst_pend", bus.o_pending,  32'h0);
        chk("postrst_busy", bus.o_div_busy, 1'b0);
        @(negedge clk);
        present("div_after_rst", 8, 4, 6, 1'b1, 1'b0, ALU_DIV, dx, ax, nr, nw, nd);
        chk("postrst_delay", dx, 0);
        idle(10);

        // Randomized traffic on a narrow register range to provoke hazards.
        for (int k = 0; k < 3000; k++) begin
            rst            = ($urandom_range(0, 99) == 0);
            bus.i_valid    = ($urandom_range(0, 3) != 0);
            bus.i_select_a = 5'($urandom_range(0, 7));
            bus.i_select_b = 5'($urandom_range(0, 7));
            bus.i_select_c = 5'($urandom_range(0, 7));
            bus.i_is_write = ($urandom_range(0, 3) != 0);
            bus.i_is_load  = ($urandom_range(0, 3) == 0);
            bus.i_is_store = ($urandom_range(0, 7) == 0);
            bus.i_is_cmp   = ($urandom_range(0, 7) == 0);
            bus.i_alu_op   = alu_op_e'($urandom_range(0, 7));
            bus.i_flush    = ($urandom_range(0, 9) == 0);
            #1;
            if (bus.o_issue) begin
                $display("txn rand cyc=%0d op=%0d a=%0d b=%0d c=%0d wr=%0b ld=%0b",
                         cyc, bus.i_alu_op, bus.i_select_a, bus.i_select_b,
                         bus.i_select_c, bus.i_is_write, bus.i_is_load);
            end
            @(negedge clk);
        end
        rst = 1'b0;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
